adc_scan: RTL and testbench
===========================

ADC_SCAN -- requirements
Module: adc_scan

Interface
REQ-001 Parameter WIDTH, default 8, sets the sample and result width in bits.
REQ-002 Parameter CHANNELS, default 4, sets the number of input channels (range 2..16).
REQ-003 Parameter CONV_CYCLES, default 4, sets the clock cycles per single conversion (range 1..255).
REQ-004 Parameter AVG_LOG2, default 0, makes each result the average of 2^AVG_LOG2 conversions (range 0..4).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  1  conversion request, sampled each rising edge.
REQ-008 scan  input  1  mode, latched with req: 0 converts one channel, 1 converts channels 0..CHANNELS-1 in order.
REQ-009 ch_sel  input  $clog2(CHANNELS)  channel to convert in single mode, latched with req.
REQ-010 ain  input  CHANNELS*WIDTH  analog-sample inputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 busy  output  1  high while a request is in progress.
REQ-012 rdy  output  1  one-cycle pulse marking a new valid result on dat/ch_out.
REQ-013 dat  output  WIDTH  latest result; held between rdy pulses.
REQ-014 ch_out  output  $clog2(CHANNELS)  channel of the latest result; held between rdy pulses.
REQ-015 overrun  output  1  sticky flag: a request arrived while busy.

Function
REQ-016 The block SHALL use two states: IDLE and CONV; busy SHALL equal (state == CONV), registered.
REQ-017 In IDLE with req=1 at edge t, the block SHALL do all of: latch scan; set the current channel to ch_sel (single mode) or 0 (scan mode); clear the cycle counter, sample counter and accumulator; and enter CONV.
REQ-018 In CONV, the cycle counter SHALL increment each edge; on the edge where it equals CONV_CYCLES-1, the block SHALL add ain[current channel] to the accumulator and increment the sample counter.
REQ-019 ain SHALL be read only on that final-cycle edge; values at other edges SHALL have no effect.
REQ-020 The accumulator SHALL be WIDTH+AVG_LOG2 bits wide and SHALL never overflow.
REQ-021 On the edge that adds the 2^AVG_LOG2-th sample, the block SHALL load dat with the sum (including that sample) right-shifted by AVG_LOG2, truncating.
REQ-022 On that same edge, the block SHALL load ch_out with the current channel, assert rdy for exactly the following cycle, and clear the accumulator and counters.
REQ-023 After a result, in single mode or on channel CHANNELS-1 in scan mode, the block SHALL return to IDLE on the same edge, so busy=0 in the rdy cycle.
REQ-024 After a result otherwise in scan mode, the block SHALL increment the channel and stay in CONV with no idle gap.
REQ-025 Latency: the result for the n-th channel of a request (n=0 first) SHALL be registered at edge t + (n+1)*CONV_CYCLES*2^AVG_LOG2.
REQ-026 A req=1 sampled while in CONV, including on the completing edge, SHALL be ignored and SHALL set overrun=1; the ongoing conversion SHALL be unaffected.
REQ-027 overrun SHALL remain 1 until rst.
REQ-028 A req in the cycle following return to IDLE SHALL be accepted normally.
REQ-029 A ch_sel value >= CHANNELS in single mode SHALL be treated as CHANNELS-1.
REQ-030 With CONV_CYCLES=1, every edge in CONV SHALL be a final-cycle edge.

Reset
REQ-031 rst=1 at an edge SHALL force state IDLE, busy=0, rdy=0, dat=0, ch_out=0, overrun=0, and clear all counters and the accumulator.
REQ-032 rst SHALL take priority over req and over completion on the same edge; a conversion aborted by rst SHALL produce no rdy.

Verification (defaults unless stated; t = edge sampling req=1)
REQ-033 Reset: rst=1 for 2 cycles during a scan -> busy, rdy, dat, ch_out, overrun all 0; no further rdy.
REQ-034 Single: ain ch2=0xA5, ch_sel=2, scan=0 -> busy=1 after edges t..t+3; rdy=1 only after edge t+4 with dat=0xA5, ch_out=2, busy=0.
REQ-035 Scan: ain ch0..3 = 0x10,0x20,0x30,0x40 -> rdy pulses after edges t+4, t+8, t+12, t+16 with dat 0x10, 0x20, 0x30, 0x40 and ch_out 0, 1, 2, 3; busy low after t+16.
REQ-036 Averaging (AVG_LOG2=2): ain ch0 = 10, 11, 12, 14 at the four final-cycle edges -> single rdy after edge t+16 with dat=11 (47>>2).
REQ-037 Overrun: req=1 at t+2 and at t+4 of a single conversion -> overrun=1 from t+3 on; result of the first request unchanged; req at t+5 accepted, with rdy after t+9.
REQ-038 Abort: rst=1 at t+2 of a single conversion -> no rdy ever; a subsequent req converts normally with latency 4.

Source files
------------

// File: rtl/adc_scan.sv
// adc_scan: multi-channel ADC sequencer with single-channel and scan modes
// and optional power-of-two averaging. Each conversion takes CONV_CYCLES
// clocks; the sample is taken on the final cycle and accumulated, and a
// result is published once 2^AVG_LOG2 samples have been summed.
module adc_scan #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int CONV_CYCLES = 4,
  parameter int AVG_LOG2    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          scan,
  input  logic [$clog2(CHANNELS)-1:0]   ch_sel,
  input  logic [CHANNELS*WIDTH-1:0]     ain,
  output logic                          busy,
  output logic                          rdy,
  output logic [WIDTH-1:0]              dat,
  output logic [$clog2(CHANNELS)-1:0]   ch_out,
  output logic                          overrun
);

  localparam int CW = $clog2(CHANNELS);
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int SW = AVG_LOG2 + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam logic [7:0]    CYC_LAST  = 8'(CONV_CYCLES - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);

  logic [0:0]       state_q, state_d;
  logic             scan_q, scan_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [7:0]       cyc_q, cyc_d;
  logic [SW-1:0]    samp_q, samp_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]    chout_q, chout_d;
  logic             rdy_q, rdy_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] sample_s;
  logic [AW-1:0]    sum_s;
  logic [AW-1:0]    avg_s;
  logic [CW-1:0]    sel_s;

  // Current channel's sample and the running sum including it. The
  // accumulator holds at most 2^AVG_LOG2 * (2^WIDTH - 1), so AW bits suffice.
  assign sample_s = ain[ch_q*WIDTH +: WIDTH];
  assign sum_s    = acc_q + AW'(sample_s);
  assign avg_s    = sum_s >> AVG_LOG2;

  // Clamp an out-of-range single-mode channel select to the last channel.
  always_comb begin
    sel_s = ch_sel;
    if ({1'b0, ch_sel} >= (CW+1)'(CHANNELS)) begin
      sel_s = CH_LAST;
    end else begin
      sel_s = ch_sel;
    end
  end

  // Next-state logic: request acceptance, conversion timing, averaging,
  // result publication and channel sequencing.
  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    ch_d    = ch_q;
    cyc_d   = cyc_q;
    samp_d  = samp_q;
    acc_d   = acc_q;
    dat_d   = dat_q;
    chout_d = chout_q;
    rdy_d   = 1'b0;
    ovr_d   = ovr_q | (req & (state_q == S_CONV));
    case (state_q)
      S_IDLE: begin
        if (req) begin
          scan_d  = scan;
          ch_d    = scan ? {CW{1'b0}} : sel_s;
          cyc_d   = 8'd0;
          samp_d  = {SW{1'b0}};
          acc_d   = {AW{1'b0}};
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = 8'd0;
          if (samp_q == SAMP_LAST) begin
            // Last sample of this channel: publish the truncated average.
            dat_d   = avg_s[WIDTH-1:0];
            chout_d = ch_q;
            rdy_d   = 1'b1;
            acc_d   = {AW{1'b0}};
            samp_d  = {SW{1'b0}};
            if (!scan_q || (ch_q == CH_LAST)) begin
              state_d = S_IDLE;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            acc_d  = sum_s;
            samp_d = samp_q + SW'(1);
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over all activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      scan_q  <= 1'b0;
      ch_q    <= {CW{1'b0}};
      cyc_q   <= 8'd0;
      samp_q  <= {SW{1'b0}};
      acc_q   <= {AW{1'b0}};
      dat_q   <= {WIDTH{1'b0}};
      chout_q <= {CW{1'b0}};
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      ch_q    <= ch_d;
      cyc_q   <= cyc_d;
      samp_q  <= samp_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      chout_q <= chout_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy    = (state_q == S_CONV);
  assign rdy     = rdy_q;
  assign dat     = dat_q;
  assign ch_out  = chout_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_adc_scan.sv
// Scoreboard bench for adc_scan: stimulus pushes expected results and status
// snapshots keyed by clock-edge number; one monitor compares on falling edges.
module tb_adc_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Instance 0: defaults (8-bit, 4 channels, 4 cycles, no averaging)
  logic        req0, scan0, busy0, rdy0, ovr0;
  logic [1:0]  sel0, cho0;
  logic [31:0] ain0;
  logic [7:0]  dat0;
  // Instance 1: 3 channels, 4-sample averaging
  logic        req1, scan1, busy1, rdy1, ovr1;
  logic [1:0]  sel1, cho1;
  logic [23:0] ain1;
  logic [7:0]  dat1;

  adc_scan dut0 (
    .clk(clk), .rst(rst), .req(req0), .scan(scan0), .ch_sel(sel0), .ain(ain0),
    .busy(busy0), .rdy(rdy0), .dat(dat0), .ch_out(cho0), .overrun(ovr0)
  );

  adc_scan #(.WIDTH(8), .CHANNELS(3), .CONV_CYCLES(4), .AVG_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .scan(scan1), .ch_sel(sel1), .ain(ain1),
    .busy(busy1), .rdy(rdy1), .dat(dat1), .ch_out(cho1), .overrun(ovr1)
  );

  // Edge counter: after rising edge k, edge_n == k.
  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  dat;
    logic [1:0]  ch;
    logic        busy;
  } rexp_t;

  typedef struct {
    int unsigned at;
    logic        busy;
    logic        ovr;
    logic        zero;
  } sexp_t;

  rexp_t exp0[$];
  rexp_t exp1[$];
  sexp_t st0[$];
  int    errors = 0;
  int    checks = 0;
  logic  done   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", nm, act, want, edge_n);
    end
  endtask

  task automatic push_r0(input int unsigned at, input logic [7:0] d, input logic [1:0] c, input logic b);
    rexp_t e;
    e.at = at; e.dat = d; e.ch = c; e.busy = b;
    exp0.push_back(e);
  endtask

  task automatic push_r1(input int unsigned at, input logic [7:0] d, input logic [1:0] c, input logic b);
    rexp_t e;
    e.at = at; e.dat = d; e.ch = c; e.busy = b;
    exp1.push_back(e);
  endtask

  task automatic push_s0(input int unsigned at, input logic b, input logic o, input logic z);
    sexp_t s;
    s.at = at; s.busy = b; s.ovr = o; s.zero = z;
    st0.push_back(s);
  endtask

  // Monitor: compares status snapshots and rdy results, then ends the run.
  always @(negedge clk) begin
    sexp_t s;
    rexp_t r;
    while (st0.size() > 0 && st0[0].at <= edge_n) begin
      s = st0.pop_front();
      chk("status_edge", edge_n, s.at);
      chk("busy0", busy0, s.busy);
      chk("overrun0", ovr0, s.ovr);
      if (s.zero) begin
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_dat0", dat0, 8'h00);
        chk("rst_ch0", cho0, 2'd0);
      end
    end
    if (rdy0) begin
      if (exp0.size() == 0) begin
        chk("rdy0_unexpected", rdy0, 1'b0);
      end else begin
        r = exp0.pop_front();
        chk("rdy0_edge", edge_n, r.at);
        chk("dat0", dat0, r.dat);
        chk("ch_out0", cho0, r.ch);
        chk("busy0_at_rdy", busy0, r.busy);
      end
    end else if (exp0.size() > 0 && exp0[0].at <= edge_n) begin
      r = exp0.pop_front();
      chk("rdy0_missing", rdy0, 1'b1);
    end
    if (rdy1) begin
      if (exp1.size() == 0) begin
        chk("rdy1_unexpected", rdy1, 1'b0);
      end else begin
        r = exp1.pop_front();
        chk("rdy1_edge", edge_n, r.at);
        chk("dat1", dat1, r.dat);
        chk("ch_out1", cho1, r.ch);
        chk("busy1_at_rdy", busy1, r.busy);
      end
    end else if (exp1.size() > 0 && exp1[0].at <= edge_n) begin
      r = exp1.pop_front();
      chk("rdy1_missing", rdy1, 1'b1);
    end
    if (done) begin
      chk("exp0_drained", exp0.size(), 0);
      chk("exp1_drained", exp1.size(), 0);
      chk("st0_drained", st0.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    int unsigned t;
    logic [7:0] avals [4];
    avals[0] = 8'd10; avals[1] = 8'd11; avals[2] = 8'd12; avals[3] = 8'd14;
    rst = 1'b1; req0 = 1'b0; scan0 = 1'b0; sel0 = 2'd0; ain0 = 32'h0;
    req1 = 1'b0; scan1 = 1'b0; sel1 = 2'd0; ain1 = 24'h0;
    repeat (2) @(negedge clk);
    push_s0(edge_n + 1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single conversion of channel 2
    ain0 = 32'h0000_0000; ain0[23:16] = 8'hA5;
    sel0 = 2'd2; scan0 = 1'b0; req0 = 1'b1; t = edge_n + 1;
    push_r0(t + 4, 8'hA5, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) push_s0(t + i, 1'b1, 1'b0, 1'b0);
    @(negedge clk); req0 = 1'b0;
    repeat (5) @(negedge clk);

    // Full scan of four channels
    ain0 = 32'h4030_2010; scan0 = 1'b1; req0 = 1'b1; t = edge_n + 1;
    for (int n = 0; n < 4; n++)
      push_r0(t + 4 * (n + 1), 8'((n + 1) * 16), 2'(n), (n == 3) ? 1'b0 : 1'b1);
    push_s0(t + 17, 1'b0, 1'b0, 1'b0);
    @(negedge clk); req0 = 1'b0;
    repeat (17) @(negedge clk);

    // Overrun during single conversion; ain sampled only on final edge
    ain0 = 32'h0000_FF00; sel0 = 2'd1; scan0 = 1'b0; req0 = 1'b1; t = edge_n + 1;
    push_r0(t + 4, 8'h5A, 2'd1, 1'b0);
    push_s0(t + 3, 1'b1, 1'b1, 1'b0);
    push_s0(t + 5, 1'b1, 1'b1, 1'b0);
    push_r0(t + 9, 8'h3C, 2'd3, 1'b0);
    push_s0(t + 10, 1'b0, 1'b1, 1'b0);
    @(negedge clk); req0 = 1'b0;
    @(negedge clk); req0 = 1'b1;
    @(negedge clk); req0 = 1'b0;
    @(negedge clk); ain0[15:8] = 8'h5A; req0 = 1'b1;
    @(negedge clk); ain0[15:8] = 8'hEE; sel0 = 2'd3; ain0[31:24] = 8'h3C;
    @(negedge clk); req0 = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a scan
    ain0 = 32'h4030_2010; scan0 = 1'b1; req0 = 1'b1; t = edge_n + 1;
    push_r0(t + 4, 8'h10, 2'd0, 1'b1);
    @(negedge clk); req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    push_s0(t + 7, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Abort a single conversion, then convert normally
    ain0 = 32'h0000_0077; sel0 = 2'd0; scan0 = 1'b0; req0 = 1'b1; t = edge_n + 1;
    @(negedge clk); req0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    push_s0(t + 2, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    ain0 = 32'h0000_0066; req0 = 1'b1; t = edge_n + 1;
    push_r0(t + 4, 8'h66, 2'd0, 1'b0);
    @(negedge clk); req0 = 1'b0;
    repeat (5) @(negedge clk);

    // Averaging: 10+11+12+14 = 47, 47>>2 = 11
    sel1 = 2'd0; scan1 = 1'b0; req1 = 1'b1; t = edge_n + 1;
    push_r1(t + 16, 8'd11, 2'd0, 1'b0);
    @(negedge clk); req1 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ain1[7:0] = avals[s];
      repeat (4) @(negedge clk);
    end
    @(negedge clk);

    // Out-of-range channel select clamps to last channel (2)
    ain1 = 24'hC8_1234; sel1 = 2'd3; req1 = 1'b1; t = edge_n + 1;
    push_r1(t + 16, 8'hC8, 2'd2, 1'b0);
    @(negedge clk); req1 = 1'b0;
    repeat (18) @(negedge clk);

    done = 1'b1;
  end

endmodule
